lector_visualizador_numerico: RTL and testbench
===============================================

# lector_visualizador_numerico

Receiver for the multiplexed 7-segment bus produced by the numeric display controller: it watches the segment pattern and the active-low digit-enable lines, waits for each digit dwell to settle, decodes the pattern back to BCD, and assembles a 4-digit frame. It sits on the loopback/self-test path next to the display controller. It recovers the frequency and CT counts actually shown on the board and flags illegal patterns and illegal digit enables.

## Interface
Parameters:
- STABLE_CYCLES, 4 — consecutive identical registered samples required before a dwell is captured; legal range 2–255.

Ports:
- clock  input  1  — single system clock; all state changes on its rising edge.
- reset  input  1  — asynchronous, active-low reset.
- code_digitos_decimal  input  8  — segment bus, active-low (0 = lit).
  - Bit 0 = a … bit 6 = g; bit 7 = dp.
  - dp is ignored.
- code_7seg  input  4  — digit enables, active-low one-hot.
  - 1110 = digit 0 (least significant) … 0111 = digit 3.
  - 1111 = no digit enabled.
- valor_bcd  output  16  — last complete frame; digit 3 in [15:12], digit 0 in [3:0].
  - Value 0–9, or 4'hF for blank/invalid.
- frame_valid  output  1  — one-cycle pulse when valor_bcd is updated.
- seg_error  output  1  — held with each frame; 1 if any digit in that frame had a non-decimal, non-blank pattern.
- anode_error  output  1  — one-cycle pulse on a settled, non-one-hot, non-idle enable pattern.

## Operation
- **Input stage:** both inputs are registered once (sample stage) before any use.
- **Stability counter:**
  - Increments while the sampled {enable, segment[6:0]} equals the previous sample.
  - Reloads to 1 on any change; saturates at STABLE_CYCLES.
- **FSM states:**
  - WAIT: enable idle or unstable. Go to SETTLE on a new sample.
  - SETTLE: counting. When the counter reaches STABLE_CYCLES, go to CAPTURE.
  - CAPTURE: one cycle; act on the settled sample. Go to HOLD.
  - HOLD: the dwell is already captured. Go to SETTLE when the sample changes.
- **Decode** (segments a..g active-low, dp masked):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90.
  - All-off (FF) = blank → 4'hF, no error.
  - Any other pattern → 4'hF and sets the frame error bit.
- **CAPTURE with a legal enable:**
  - Write the decoded value into the shadow slot for that digit.
  - Set that digit's bit in the capture mask.
  - OR the decode error into the frame error flag.
- **CAPTURE with enable 1111:** no action.
- **CAPTURE with any other enable:**
  - Pulse anode_error.
  - Clear the mask and the frame error flag (frame aborted); shadow values stay.
- **Frame completion:** when the mask reaches 1111, on the next edge:
  - valor_bcd ← shadow.
  - seg_error ← frame error flag.
  - frame_valid = 1 for one cycle.
  - Mask and frame error flag cleared.
- **Recapture before completion:** a digit captured again before the frame completes overwrites its shadow slot. Its mask bit is already set.
- **Reset:**
  - valor_bcd = 16'hFFFF; frame_valid = 0; seg_error = 0; anode_error = 0.
  - Mask = 0; shadow = all 4'hF; counter = 0; FSM = WAIT.
  - Reset asserted mid-frame discards the partial frame.

## Timing
- **Capture latency:** a pattern first presented before rising edge k is sampled at k. If held unchanged, CAPTURE executes at edge k+STABLE_CYCLES.
- **Frame output latency:** valor_bcd and frame_valid update one edge after the capture that completes the mask.
- **Short dwells:** dwells shorter than STABLE_CYCLES clocks are never captured.
- **One capture per dwell:** a dwell longer than STABLE_CYCLES clocks is captured exactly once.
- **Glitches:** a single-cycle glitch inside a dwell restarts settling, so the same dwell may be captured a second time (value overwrite only).
- **Simultaneous events:** mask completion and anode_error cannot coincide, because CAPTURE handles one event per cycle. An abort in the cycle where the mask is already 1111 does not cancel the pending publish; publish takes priority.
- **Scan order:** no ordering is assumed; any scan order that visits all four digits completes a frame.

## Structure
- **Shared package `visualizador_pkg`:**
  - Segment constants SEG_0…SEG_9 and SEG_BLANK.
  - Enable codes AN_DIG0…AN_DIG3 and AN_IDLE.
  - BCD_BLANK = 4'hF.
  - FSM state enumeration.
- **Sub-module:** one combinational sub-module, `decodificador_7seg_bcd` (segment[6:0] → {error, bcd[3:0]}), instantiated once after the sample stage.
- **Top level contains:** sample registers, stability counter, FSM, shadow/mask/flag registers and output registers.

## Test plan
1. **Normal scan:** scan digits 0..3 with patterns 9,4,0,2 (90,99,C0,A4), 8-cycle dwells, STABLE_CYCLES=4 → one frame_valid pulse; valor_bcd=16'h2049; seg_error=0.
2. **Short dwells:** dwells of 3 cycles → no frame_valid ever. Then 4-cycle dwells → frame published 1 edge after the 4th capture.
3. **Illegal pattern:** digit 2 shows 8'hFE (only a segment lit), rest legal 1,2,3 → valor_bcd=16'h3F21 (digit 3 = 3, digit 2 = F); seg_error=1. Next clean frame clears seg_error.
4. **Illegal enable:** code_7seg=1100 held 6 cycles mid-frame → anode_error pulses once; the following full scan of 5,5,5,5 publishes 16'h5555 with no stale data.
5. **Reset mid-frame:** reset low after 2 of 4 captures → all outputs back to reset values immediately. After release, a full scan of 1,2,3,4 → 16'h4321.
6. **Blank and dp:** all segments off on digit 3 and dp lit on digit 0 (7 = 78) → valor_bcd=16'hF..7 form with digit 3 = F; seg_error=0.

Source files
------------

// File: rtl/visualizador_pkg.sv
// visualizador_pkg: segment/enable codes, BCD blank value and FSM states
// shared by the 7-segment loopback reader.
package visualizador_pkg;
  // Segment patterns are active-low and use bit 0 = a ... bit 6 = g, with dp = 1 (off).
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_DIG0   = 4'b1110;
  localparam logic [3:0] AN_DIG1   = 4'b1101;
  localparam logic [3:0] AN_DIG2   = 4'b1011;
  localparam logic [3:0] AN_DIG3   = 4'b0111;
  localparam logic [3:0] AN_IDLE   = 4'b1111;
  localparam logic [3:0] BCD_BLANK = 4'hF;
  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_CAPTURE, ST_HOLD} estado_t;
  function automatic logic an_legal(input logic [3:0] an);
    return (an == AN_DIG0) || (an == AN_DIG1) || (an == AN_DIG2) || (an == AN_DIG3);
  endfunction
endpackage

// File: rtl/decodificador_7seg_bcd.sv
// decodificador_7seg_bcd: active-low segment pattern -> BCD digit.
//   i_seg   : segments a..g (bit 0 = a), active-low
//   o_bcd   : 0-9, or BCD_BLANK for blank/illegal patterns
//   o_error : 1 for a pattern that is neither a decimal digit nor blank
module decodificador_7seg_bcd
  import visualizador_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_error,
  output logic [3:0] o_bcd
);
  always_comb begin
    o_error = 1'b0;
    o_bcd   = BCD_BLANK;
    case (i_seg)
      SEG_0[6:0]:     o_bcd = 4'd0;
      SEG_1[6:0]:     o_bcd = 4'd1;
      SEG_2[6:0]:     o_bcd = 4'd2;
      SEG_3[6:0]:     o_bcd = 4'd3;
      SEG_4[6:0]:     o_bcd = 4'd4;
      SEG_5[6:0]:     o_bcd = 4'd5;
      SEG_6[6:0]:     o_bcd = 4'd6;
      SEG_7[6:0]:     o_bcd = 4'd7;
      SEG_8[6:0]:     o_bcd = 4'd8;
      SEG_9[6:0]:     o_bcd = 4'd9;
      SEG_BLANK[6:0]: o_bcd = BCD_BLANK;
      default:        o_error = 1'b1;
    endcase
  end
endmodule

// File: rtl/lector_visualizador_numerico.sv
// lector_visualizador_numerico: recovers 4-digit BCD frames from a multiplexed
// 7-segment bus by waiting for each digit dwell to settle and decoding it.
//   clock, reset (async, active-low)
//   code_digitos_decimal : segment bus, active-low, bit 7 = dp (ignored)
//   code_7seg            : active-low one-hot digit enables, 1111 = idle
//   valor_bcd            : last complete frame, digit 3 in [15:12]
//   frame_valid          : one-cycle pulse when valor_bcd updates
//   seg_error            : frame contained an illegal segment pattern
//   anode_error          : one-cycle pulse on a settled illegal enable pattern
module lector_visualizador_numerico
  import visualizador_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  code_digitos_decimal,
  input  logic [3:0]  code_7seg,
  output logic [15:0] valor_bcd,
  output logic        frame_valid,
  output logic        seg_error,
  output logic        anode_error
);
  localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);
  localparam logic [10:0] LP_IDLE_SMP = {AN_IDLE, SEG_BLANK[6:0]};
  logic [10:0] r_smp, r_prev;
  logic [7:0]  r_cnt;
  estado_t     r_st;
  logic [15:0] r_shadow;
  logic [3:0]  r_mask;
  logic        r_ferr;
  logic        w_change, w_err;
  logic [7:0]  w_cnt_next;
  logic [3:0]  w_en, w_bcd;
  logic        w_unused_dp;
  assign w_unused_dp = code_digitos_decimal[7];
  assign w_change    = r_smp != r_prev;
  assign w_cnt_next  = w_change ? 8'd1 : (r_cnt == LP_STABLE ? r_cnt : r_cnt + 8'd1);
  // r_prev holds the settled sample during CAPTURE, even if r_smp has moved on.
  assign w_en        = r_prev[10:7];
  decodificador_7seg_bcd u_dec (
    .i_seg   (r_prev[6:0]),
    .o_error (w_err),
    .o_bcd   (w_bcd)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_smp       <= LP_IDLE_SMP;
      r_prev      <= LP_IDLE_SMP;
      r_cnt       <= 8'd0;
      r_st        <= ST_WAIT;
      r_shadow    <= 16'hFFFF;
      r_mask      <= 4'd0;
      r_ferr      <= 1'b0;
      valor_bcd   <= 16'hFFFF;
      frame_valid <= 1'b0;
      seg_error   <= 1'b0;
      anode_error <= 1'b0;
    end else begin
      r_smp       <= {code_7seg, code_digitos_decimal[6:0]};
      r_prev      <= r_smp;
      r_cnt       <= w_cnt_next;
      frame_valid <= 1'b0;
      anode_error <= 1'b0;
      case (r_st)
        ST_WAIT, ST_HOLD: r_st <= w_change ? ST_SETTLE : r_st;
        ST_SETTLE:        r_st <= (w_cnt_next == LP_STABLE) ? ST_CAPTURE : ST_SETTLE;
        // A dwell exactly STABLE_CYCLES long already changed by now; resume settling directly.
        default:          r_st <= w_change ? ST_SETTLE : (w_en == AN_IDLE ? ST_WAIT : ST_HOLD);
      endcase
      if (r_st == ST_CAPTURE) begin
        if (an_legal(w_en)) begin
          for (int i = 0; i < 4; i++)
            if (!w_en[i]) r_shadow[i*4 +: 4] <= w_bcd;
          r_mask <= r_mask | ~w_en;
          r_ferr <= r_ferr | w_err;
        end else if (w_en != AN_IDLE) begin
          anode_error <= 1'b1;
          r_mask      <= 4'd0;
          r_ferr      <= 1'b0;
        end
      end
      // Publishing is placed last so it wins over an abort in the same cycle.
      if (r_mask == 4'hF) begin
        valor_bcd   <= r_shadow;
        seg_error   <= r_ferr;
        frame_valid <= 1'b1;
        r_mask      <= 4'd0;
        r_ferr      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lector_visualizador_numerico.sv
// tb_lector_visualizador_numerico: directed scans of the 7-segment bus with hand-computed frames.
module tb_lector_visualizador_numerico;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  code_digitos_decimal = 8'hFF;
  logic [3:0]  code_7seg = 4'hF;
  logic [15:0] valor_bcd;
  logic        frame_valid, seg_error, anode_error;
  int          n_checks = 0, n_pass = 0;
  int          n_frames = 0, n_an = 0, f0, a0;
  logic [15:0] last_val = 16'h0;
  logic        last_err = 1'b0;

  lector_visualizador_numerico #(.STABLE_CYCLES(4)) dut (
    .clock                (clock),
    .reset                (reset),
    .code_digitos_decimal (code_digitos_decimal),
    .code_7seg            (code_7seg),
    .valor_bcd            (valor_bcd),
    .frame_valid          (frame_valid),
    .seg_error            (seg_error),
    .anode_error          (anode_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (frame_valid) begin
      n_frames++;
      last_val = valor_bcd;
      last_err = seg_error;
    end
    if (anode_error) n_an++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic show(input logic [3:0] an, input logic [7:0] seg, input int n);
    code_7seg = an;
    code_digitos_decimal = seg;
    repeat (n) @(negedge clock);
  endtask

  task automatic scan(input logic [7:0] s0, s1, s2, s3, input int d);
    show(4'b1110, s0, d);
    show(4'b1101, s1, d);
    show(4'b1011, s2, d);
    show(4'b0111, s3, d);
    show(4'b1111, 8'hFF, 8);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst valor", 32'(valor_bcd), 32'hFFFF);
    check("rst fv", 32'(frame_valid), 32'h0);
    check("rst se", 32'(seg_error), 32'h0);
    check("rst ae", 32'(anode_error), 32'h0);
    reset = 1'b1;
    show(4'hF, 8'hFF, 4);

    f0 = n_frames;
    scan(8'h90, 8'h99, 8'hC0, 8'hA4, 8);
    check("t1 frames", 32'(n_frames - f0), 32'd1);
    check("t1 valor", 32'(last_val), 32'h2049);
    check("t1 se", 32'(last_err), 32'h0);

    f0 = n_frames;
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 3);
    scan(8'hF9, 8'hA4, 8'hB0, 8'h99, 3);
    check("t2 short frames", 32'(n_frames - f0), 32'd0);
    scan(8'h82, 8'hF8, 8'h80, 8'h90, 4);
    check("t2 frames", 32'(n_frames - f0), 32'd1);
    check("t2 valor", 32'(last_val), 32'h9876);

    f0 = n_frames;
    scan(8'hF9, 8'hA4, 8'hFE, 8'hB0, 8);
    check("t3 valor", 32'(last_val), 32'h3F21);
    check("t3 se", 32'(last_err), 32'h1);
    scan(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8);
    check("t3 frames", 32'(n_frames - f0), 32'd2);
    check("t3 clean valor", 32'(last_val), 32'h0000);
    check("t3 clean se", 32'(last_err), 32'h0);

    f0 = n_frames;
    a0 = n_an;
    show(4'b1110, 8'hF8, 8);
    show(4'b1101, 8'hF8, 8);
    show(4'b1100, 8'hC0, 6);
    show(4'b1111, 8'hFF, 6);
    check("t4 anode pulses", 32'(n_an - a0), 32'd1);
    show(4'b1011, 8'h92, 8);
    show(4'b0111, 8'h92, 8);
    show(4'b1111, 8'hFF, 8);
    check("t4 aborted frames", 32'(n_frames - f0), 32'd0);
    show(4'b1110, 8'h92, 8);
    show(4'b1101, 8'h92, 8);
    show(4'b1111, 8'hFF, 8);
    check("t4 frames", 32'(n_frames - f0), 32'd1);
    check("t4 valor", 32'(last_val), 32'h5555);
    check("t4 se", 32'(last_err), 32'h0);

    f0 = n_frames;
    show(4'b1110, 8'h90, 8);
    show(4'b1101, 8'h90, 8);
    reset = 1'b0;
    #1;
    check("t5 rst valor", 32'(valor_bcd), 32'hFFFF);
    check("t5 rst fv", 32'(frame_valid), 32'h0);
    check("t5 rst se", 32'(seg_error), 32'h0);
    check("t5 rst ae", 32'(anode_error), 32'h0);
    show(4'b1111, 8'hFF, 3);
    reset = 1'b1;
    show(4'b1111, 8'hFF, 3);
    show(4'b1011, 8'hB0, 8);
    show(4'b0111, 8'h99, 8);
    show(4'b1111, 8'hFF, 8);
    check("t5 partial frames", 32'(n_frames - f0), 32'd0);
    show(4'b1110, 8'hF9, 8);
    show(4'b1101, 8'hA4, 8);
    show(4'b1111, 8'hFF, 8);
    check("t5 frames", 32'(n_frames - f0), 32'd1);
    check("t5 valor", 32'(last_val), 32'h4321);

    f0 = n_frames;
    scan(8'h78, 8'hF9, 8'hA4, 8'hFF, 8);
    check("t6 frames", 32'(n_frames - f0), 32'd1);
    check("t6 valor", 32'(last_val), 32'hF217);
    check("t6 se", 32'(last_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
